// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
// State encoding, size codes and the IO address match.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } state_t;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] IO_MATCH = 2'b11;

  function automatic logic [2:0] size_bytes(
    input logic [1:0] sz
  );
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector.
// Fixed: highest index wins; round-robin: first after last.
module arb_pick #(
  parameter int NUM_CH  = 2,
  parameter int RR_MODE = 0,
  parameter int IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     last,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     idx
);

  // walk candidates so the preferred one is assigned last
  always_comb begin
    grant = '0;
    idx   = '0;
    if (RR_MODE != 0) begin
      for (int i = NUM_CH; i >= 1; i--) begin
        if (req[(int'(last) + i) % NUM_CH]) begin
          grant = '0;
          grant[(int'(last) + i) % NUM_CH] = 1'b1;
          idx = IW'((int'(last) + i) % NUM_CH);
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (req[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
          idx      = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Byte-serial memory arbiter for fetch/data ports.
// One transfer at a time, one byte per cycle.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int RR_MODE = 0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 io_buffer_full,
  input  logic [7:0]           mem_din,
  output logic [7:0]           mem_dout,
  output logic [31:0]          mem_a,
  output logic                 mem_wr,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [NUM_CH-1:0]    req_wr,
  input  logic [2*NUM_CH-1:0]  req_size,
  input  logic [32*NUM_CH-1:0] req_addr,
  input  logic [32*NUM_CH-1:0] req_wdata,
  output logic [NUM_CH-1:0]    req_ready,
  output logic [NUM_CH-1:0]    resp_valid,
  output logic [31:0]          resp_rdata
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t             state, state_nx;
  logic [IW-1:0]      ptr, owner, gidx;
  logic [NUM_CH-1:0]  grant, resp_q;
  logic [31:0]        addr, wdata, buf_q, cur;
  logic [31:0]        sel_addr, sel_wdata;
  logic [1:0]         sel_size;
  logic [2:0]         nb, k, rd_idx;
  logic               dv, accept, sel_wr;
  logic               rd_issue, rd_last, rd_cap;
  logic               wr_io, wr_go, wr_last;

  arb_pick #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE),
    .IW      (IW)
  ) u_pick (
    .req   (req_valid),
    .last  (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign accept = rst_in && rdy_in && !clear
               && (state == ST_IDLE) && (|req_valid);
  assign req_ready = accept ? grant : '0;

  assign sel_wr    = req_wr[gidx];
  assign sel_size  = req_size[2*int'(gidx) +: 2];
  assign sel_addr  = req_addr[32*int'(gidx) +: 32];
  assign sel_wdata = req_wdata[32*int'(gidx) +: 32];

  // k counts captured bytes; dv marks a byte in flight on mem_din
  assign rd_idx   = k + {2'b00, dv};
  assign rd_issue = (state == ST_READ) && (rd_idx < nb);
  assign rd_cap   = (state == ST_READ) && dv && rdy_in && !clear;
  assign rd_last  = (state == ST_READ) && dv && (k + 3'd1 == nb);

  assign cur = addr + {29'd0, (state == ST_READ) ? rd_idx : k};

  assign wr_io   = (cur[17:16] == IO_MATCH) && io_buffer_full;
  assign wr_go   = (state == ST_WRITE) && rdy_in && !wr_io;
  assign wr_last = wr_go && (k == nb - 3'd1);

  assign resp_valid = resp_q;
  assign resp_rdata = buf_q;

  // state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // next state and memory bus drive
  always_comb begin
    state_nx = state;
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nx = sel_wr ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        if (rd_issue) mem_a = cur;
        if (rdy_in && (clear || rd_last)) state_nx = ST_IDLE;
      end
      ST_WRITE: begin
        mem_a    = cur;
        mem_dout = wdata[{k[1:0], 3'b000} +: 8];
        mem_wr   = wr_go;
        if (wr_last) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // transfer context, byte capture and completion pulse
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ptr    <= IW'(NUM_CH - 1);
      owner  <= '0;
      addr   <= '0;
      wdata  <= '0;
      nb     <= '0;
      k      <= '0;
      dv     <= 1'b0;
      buf_q  <= '0;
      resp_q <= '0;
    end else begin
      resp_q <= '0;
      dv     <= rd_issue && rdy_in && !clear;
      if (accept) begin
        ptr   <= gidx;
        owner <= gidx;
        addr  <= sel_addr;
        wdata <= sel_wdata;
        nb    <= size_bytes(sel_size);
        k     <= '0;
        buf_q <= '0;
      end
      if (rd_cap) begin
        buf_q[{k[1:0], 3'b000} +: 8] <= mem_din;
        k <= k + 3'd1;
        if (rd_last) resp_q <= NUM_CH'(1) << owner;
      end
      if (wr_go) begin
        k <= k + 3'd1;
        if (wr_last) resp_q <= NUM_CH'(1) << owner;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed cases plus random traffic
// against a transaction-level model and a byte memory.
module tb_mem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rdy, clr, iof;

  logic [7:0]  din, dout;
  logic [31:0] ma, rdata;
  logic        mwr;
  logic [1:0]  vld, wr, rdyv, rsp;
  logic [3:0]  sz;
  logic [63:0] ad, wd;

  logic [7:0]  r_din, r_dout;
  logic [31:0] r_ma, r_rdata;
  logic        r_mwr;
  logic [2:0]  r_vld, r_wr, r_rdy, r_rsp;
  logic [5:0]  r_sz;
  logic [95:0] r_ad, r_wd;

  logic [7:0] bmem [0:4095];
  logic [7:0] rmem [0:4095];

  int n_vec, n_err;

  mem_arb #(.NUM_CH(2), .RR_MODE(0)) u_fix (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .clear(clr),
    .io_buffer_full(iof), .mem_din(din), .mem_dout(dout),
    .mem_a(ma), .mem_wr(mwr), .req_valid(vld), .req_wr(wr),
    .req_size(sz), .req_addr(ad), .req_wdata(wd),
    .req_ready(rdyv), .resp_valid(rsp), .resp_rdata(rdata)
  );

  mem_arb #(.NUM_CH(3), .RR_MODE(1)) u_rr (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .clear(clr),
    .io_buffer_full(iof), .mem_din(r_din), .mem_dout(r_dout),
    .mem_a(r_ma), .mem_wr(r_mwr), .req_valid(r_vld), .req_wr(r_wr),
    .req_size(r_sz), .req_addr(r_ad), .req_wdata(r_wd),
    .req_ready(r_rdy), .resp_valid(r_rsp), .resp_rdata(r_rdata)
  );

  function automatic logic [7:0] init_b(input int i);
    if (i >= 'h100 && i <= 'h103) return 8'(8'h11 * (i - 'hFF));
    return 8'(i * 37 + 5);
  endfunction

  // byte memory with one-cycle read latency
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) bmem[i] <= init_b(i);
    end else if (mwr) begin
      bmem[ma[11:0]] <= dout;
    end
    din <= bmem[ma[11:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    vld = '0; wr = '0; sz = '0; ad = '0; wd = '0;
    clr = 1'b0; iof = 1'b0; rdy = 1'b1;
    r_vld = '0; r_wr = '0; r_sz = '0; r_ad = '0; r_wd = '0;
    r_din = '0;
  endtask

  task automatic put(input int ch, input logic w, input logic [1:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    vld[ch] = 1'b1;
    wr[ch]  = w;
    sz[2*ch +: 2]  = s;
    ad[32*ch +: 32] = a;
    wd[32*ch +: 32] = d;
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // random-phase model state
  logic        pend [2];
  logic        pwr  [2];
  logic [1:0]  psz  [2];
  logic [31:0] pad  [2];
  logic [31:0] pwd  [2];
  logic [1:0]  eg;
  logic [2:0]  rg;
  logic [31:0] resp_d;
  logic        resp_w, seen, got;
  int free_at, resp_at, resp_ch, gch, n, nd, bad, ptr, gj;
  int seq [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 4096; i++) rmem[i] = init_b(i);
    seq = '{0, 1, 2, 0};

    // reset with requests pending
    idle_in();
    rst_n = 1'b0;
    vld   = 2'b11;
    r_vld = 3'b111;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(rdyv), 0);
    chk("rst_rr_ready", 32'(r_rdy), 0);
    chk("rst_resp", 32'(rsp), 0);
    chk("rst_rr_resp", 32'(r_rsp), 0);
    chk("rst_a", ma, 0);
    chk("rst_wr", 32'(mwr), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rr_bus", r_ma | 32'(r_dout) | 32'(r_mwr) | r_rdata, 0);
    @(negedge clk);
    idle_in();
    rst_n = 1'b1;

    // reset in the middle of a read: no response afterwards
    @(negedge clk); idle_in(); put(0, 0, 2'b10, 32'h100, 0);
    #1 chk("t6_grant", 32'(rdyv), 2'b01);
    @(negedge clk); idle_in();
    @(negedge clk); rst_n = 1'b0;
    #1 chk("t6_rst_a", ma, 0);
    chk("t6_rst_resp", 32'(rsp), 0);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (rsp != 0) bad++;
    end
    chk("t6_noresp", bad, 0);

    // word read at 0x100
    @(negedge clk); idle_in(); put(0, 0, 2'b10, 32'h100, 0);
    #1 chk("t1_grant", 32'(rdyv), 2'b01);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); idle_in(); #1;
      if (c <= 4) begin
        chk("t1_addr", ma, 32'h100 + 32'(c - 1));
        chk("t1_wr", 32'(mwr), 0);
      end
      if (c == 5) chk("t1_early", 32'(rsp), 0);
      if (c == 6) begin
        chk("t1_resp", 32'(rsp), 2'b01);
        chk("t1_data", rdata, 32'h4433_2211);
      end
    end

    // simultaneous requests, fixed priority
    @(negedge clk); idle_in();
    put(1, 1, 2'b00, 32'h200, 32'hAB);
    put(0, 0, 2'b00, 32'h100, 0);
    #1 chk("t2_g1", 32'(rdyv), 2'b10);
    rmem['h200] = 8'hAB;
    @(negedge clk); vld[1] = 1'b0; #1;
    chk("t2_wr", 32'(mwr), 1);
    chk("t2_addr", ma, 32'h200);
    chk("t2_dout", 32'(dout), 32'hAB);
    chk("t2_busy", 32'(rdyv), 0);
    @(negedge clk); #1;
    chk("t2_resp1", 32'(rsp), 2'b10);
    chk("t2_g0", 32'(rdyv), 2'b01);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); idle_in(); #1;
      if (c == 3) begin
        chk("t2_resp0", 32'(rsp), 2'b01);
        chk("t2_data0", rdata, 32'h11);
      end
    end

    // IO write stalled by a full UART buffer
    @(negedge clk); idle_in();
    put(1, 1, 2'b00, 32'h0003_0000, 32'h41); iof = 1'b1;
    #1 chk("t3_grant", 32'(rdyv), 2'b10);
    rmem[0] = 8'h41;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); idle_in(); iof = (c <= 3); #1;
      if (c <= 3) begin
        chk("t3_hold_wr", 32'(mwr), 0);
        chk("t3_hold_a", ma, 32'h0003_0000);
      end
      if (c == 4) begin
        chk("t3_wr", 32'(mwr), 1);
        chk("t3_dout", 32'(dout), 32'h41);
      end
      if (c == 5) begin
        chk("t3_once", 32'(mwr), 0);
        chk("t3_resp", 32'(rsp), 2'b10);
      end
    end

    // clear during second byte of a word read
    @(negedge clk); idle_in(); put(0, 0, 2'b10, 32'h100, 0);
    #1 chk("t4_grant", 32'(rdyv), 2'b01);
    @(negedge clk); idle_in();
    @(negedge clk); clr = 1'b1;
    #1 chk("t4_a2", ma, 32'h101);
    @(negedge clk); idle_in(); put(0, 0, 2'b00, 32'h103, 0);
    #1 chk("t4_idle_g", 32'(rdyv), 2'b01);
    chk("t4_noresp", 32'(rsp), 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); idle_in(); #1;
      chk("t4_resp", 32'(rsp), (c == 3) ? 32'h1 : 32'h0);
      if (c == 3) chk("t4_data", rdata, 32'h44);
    end

    // clear during a half write does not abort it
    @(negedge clk); idle_in(); put(1, 1, 2'b01, 32'h210, 32'hBEEF);
    #1 chk("t4b_grant", 32'(rdyv), 2'b10);
    rmem['h210] = 8'hEF;
    rmem['h211] = 8'hBE;
    @(negedge clk); idle_in(); clr = 1'b1; #1;
    chk("t4b_wr0", {31'd0, mwr}, 1);
    chk("t4b_a0", ma, 32'h210);
    chk("t4b_d0", 32'(dout), 32'hEF);
    @(negedge clk); idle_in(); #1;
    chk("t4b_wr1", {31'd0, mwr}, 1);
    chk("t4b_a1", ma, 32'h211);
    chk("t4b_d1", 32'(dout), 32'hBE);
    @(negedge clk); idle_in(); #1;
    chk("t4b_resp", 32'(rsp), 2'b10);

    // pause for two cycles mid word read
    @(negedge clk); idle_in(); put(0, 0, 2'b10, 32'h100, 0);
    #1 chk("t5_grant", 32'(rdyv), 2'b01);
    seen = 1'b0;
    got  = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); idle_in(); rdy = !(c == 3 || c == 4); #1;
      if (c == 3 || c == 4) chk("t5_pause_resp", 32'(rsp), 0);
      if (c >= 5 && ma == 32'h102) seen = 1'b1;
      if (rsp != 0 && !got) begin
        got = 1'b1;
        chk("t5_resp", 32'(rsp), 2'b01);
        chk("t5_data", rdata, 32'h4433_2211);
      end
    end
    chk("t5_reissue", 32'(seen), 1);
    chk("t5_done", 32'(got), 1);

    // random traffic on the fixed-priority instance
    @(negedge clk); idle_in();
    for (int i = 0; i < 2; i++) pend[i] = 1'b0;
    free_at = 0;
    resp_at = -1;
    resp_ch = 0;
    resp_w  = 1'b0;
    resp_d  = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        if (!pend[ch] && $urandom_range(0, 2) == 0) begin
          pend[ch] = 1'b1;
          pwr[ch]  = 1'($urandom_range(0, 1));
          psz[ch]  = 2'($urandom_range(0, 3));
          pad[ch]  = ($urandom_range(0, 3) == 0)
                   ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                   : $urandom();
          pwd[ch]  = $urandom();
        end
      end
      idle_in();
      for (int ch = 0; ch < 2; ch++)
        if (pend[ch]) put(ch, pwr[ch], psz[ch], pad[ch], pwd[ch]);
      #1;
      eg = 2'b00;
      if (c >= free_at) begin
        if (pend[1])      eg = 2'b10;
        else if (pend[0]) eg = 2'b01;
      end
      chk("rnd_ready", 32'(rdyv), 32'(eg));
      chk("rnd_resp", 32'(rsp), (c == resp_at) ? (32'h1 << resp_ch) : 0);
      if (c == resp_at && !resp_w) chk("rnd_rdata", rdata, resp_d);
      if (eg != 2'b00) begin
        gch = eg[1] ? 1 : 0;
        n   = nbytes(psz[gch]);
        if (pwr[gch]) begin
          for (int b = 0; b < n; b++)
            rmem[(pad[gch] + 32'(b)) & 32'hFFF] = pwd[gch][8*b +: 8];
          resp_at = c + n + 1;
        end else begin
          resp_d = '0;
          for (int b = 0; b < n; b++)
            resp_d[8*b +: 8] = rmem[(pad[gch] + 32'(b)) & 32'hFFF];
          resp_at = c + n + 2;
        end
        free_at  = resp_at;
        resp_ch  = gch;
        resp_w   = pwr[gch];
        pend[gch] = 1'b0;
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); idle_in();
    end
    nd = 0;
    for (int i = 0; i < 4096; i++) if (bmem[i] !== rmem[i]) nd++;
    chk("memimg", nd, 0);

    // round-robin instance: all valid first, then random masks
    ptr = 2;
    free_at = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); idle_in();
      r_vld = (c < 12) ? 3'b111 : 3'($urandom_range(0, 7));
      #1;
      rg = 3'b000;
      gj = -1;
      if (c >= free_at) begin
        for (int i = 3; i >= 1; i--)
          if (r_vld[(ptr + i) % 3]) gj = (ptr + i) % 3;
      end
      if (gj >= 0) rg = 3'(1 << gj);
      chk("rr_ready", 32'(r_rdy), 32'(rg));
      if (c < 12 && c % 3 == 0)
        chk("rr_seq", 32'(r_rdy), 32'h1 << seq[c / 3]);
      if (gj >= 0) begin
        ptr = gj;
        free_at = c + 3;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
